dm_arbiter: RTL

- Shares the single-port 256x8 data memory between two requesters: the core load/store path (port C) and a host/debug loader (port H) that preloads operands and reads results.
- Sits between the core datapath and the data memory.
- Provides round-robin arbitration, an optional host lock for burst transfers with a bounded hold time, and registered read-data return with a one-cycle valid pulse.

---
 rtl/dm_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//
// Shares one single-port data memory (2**AW x DW, asynchronous read) between
// the core load/store path (port C) and a host/debug loader (port H).
//
// Arbitration
//   - ARB    : a lone requester wins. If both ports request, the port that was
//              not granted last wins (round-robin).
//   - LOCKED : entered when the host is granted with HostLock=1. The host keeps
//              the memory for up to MAX_HOLD consecutive grants while the core
//              waits. After that the core is forced in for one access. With an
//              idle core, the host keeps the grant indefinitely.
//   Grants are combinational from the requests and the state. The access
//   commits at the next rising edge of Clk.
//
// Read return
//   A granted read captures MemRdData into that port's RdData register at the
//   commit edge. The port's Valid is high for exactly the following cycle.
//   Writes never raise Valid.
//
// Ports
//   Clk, Reset_n                  clock, asynchronous active-low reset
//   CoreReq/We/Addr/WrData        core request, write enable, address, data
//   CoreGnt, CoreStall            core access commits at this edge / core waits
//   CoreRdData, CoreValid         registered core read data and valid pulse
//   HostReq/We/Lock/Addr/WrData   host request, write enable, lock, addr, data
//   HostGnt                       host access commits at this edge
//   HostRdData, HostValid         registered host read data and valid pulse
//   MemAddr/WrEn/WrData           to the data memory
//   MemRdData                     asynchronous read data from the data memory
// ---------------------------------------------------------------------------
module dm_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic          Clk,
   input  logic          Reset_n,
   // core port
   input  logic          CoreReq,
   input  logic          CoreWe,
   input  logic [AW-1:0] CoreAddr,
   input  logic [DW-1:0] CoreWrData,
   output logic          CoreGnt,
   output logic          CoreStall,
   output logic [DW-1:0] CoreRdData,
   output logic          CoreValid,
   // host port
   input  logic          HostReq,
   input  logic          HostWe,
   input  logic          HostLock,
   input  logic [AW-1:0] HostAddr,
   input  logic [DW-1:0] HostWrData,
   output logic          HostGnt,
   output logic [DW-1:0] HostRdData,
   output logic          HostValid,
   // data memory
   output logic [AW-1:0] MemAddr,
   output logic          MemWrEn,
   output logic [DW-1:0] MemWrData,
   input  logic [DW-1:0] MemRdData
);

   // The hold counter must be able to represent MAX_HOLD itself.
   localparam int             HW       = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0]  HOLD_ONE = HW'(1);

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_H = 1'b1
   } port_t;

   state_t        state, state_nxt;
   port_t         last, last_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;

   logic core_gnt, host_gnt;
   logic rr_core, rr_host;
   logic core_rd, host_rd;

   // ------------------------------------------------------------------------
   // Next-state and grant logic
   // ------------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      core_gnt  = 1'b0;
      host_gnt  = 1'b0;
      state_nxt = state;
      last_nxt  = last;
      hold_nxt  = hold_cnt;

      // Round-robin choice: on a tie, the port that did not win last time wins.
      rr_core = CoreReq && (!HostReq || (last == PORT_H));
      rr_host = HostReq && (!CoreReq || (last == PORT_C));

      unique case (state)
         ARB: begin
            core_gnt = rr_core;
            host_gnt = rr_host;
            if (rr_host && HostLock) begin
               state_nxt = LOCKED;
               hold_nxt  = HOLD_ONE;
            end
         end

         LOCKED: begin
            if (HostReq && HostLock) begin
               if ((hold_cnt < HOLD_MAX) || !CoreReq) begin
                  host_gnt = 1'b1;
                  // Saturate so an idle core never causes a wrap to zero.
                  if (hold_cnt < HOLD_MAX) begin
                     hold_nxt = hold_cnt + HOLD_ONE;
                  end
               end else begin
                  // Hold budget spent and the core is waiting: forced release.
                  core_gnt  = 1'b1;
                  state_nxt = ARB;
                  hold_nxt  = '0;
               end
            end else begin
               // Lock dropped: plain round-robin. The host owned the last
               // grant, so a waiting core wins any tie.
               core_gnt  = CoreReq;
               host_gnt  = HostReq && !CoreReq;
               state_nxt = ARB;
               hold_nxt  = '0;
            end
         end

         default: begin
            state_nxt = ARB;
            hold_nxt  = '0;
         end
      endcase

      if (core_gnt) begin
         last_nxt = PORT_C;
      end else if (host_gnt) begin
         last_nxt = PORT_H;
      end

      // Grants are suppressed combinationally while reset is asserted, so no
      // memory write can occur during reset even with requests present.
      if (!Reset_n) begin
         core_gnt = 1'b0;
         host_gnt = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ARB;
         last     <= PORT_H;   // core wins the first tie after reset
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Memory mux: the granted port drives the memory. With no grant the write
   // enable is off and the address/data are don't-care (core values).
   // ------------------------------------------------------------------------
   assign MemAddr   = host_gnt ? HostAddr   : CoreAddr;
   assign MemWrData = host_gnt ? HostWrData : CoreWrData;
   assign MemWrEn   = (core_gnt && CoreWe) || (host_gnt && HostWe);

   assign CoreGnt   = core_gnt;
   assign HostGnt   = host_gnt;
   assign CoreStall = CoreReq && !core_gnt;

   // ------------------------------------------------------------------------
   // Read return registers
   // ------------------------------------------------------------------------
   assign core_rd = core_gnt && !CoreWe;
   assign host_rd = host_gnt && !HostWe;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         CoreRdData <= '0;
         CoreValid  <= 1'b0;
         HostRdData <= '0;
         HostValid  <= 1'b0;
      end else begin
         CoreValid <= core_rd;
         HostValid <= host_rd;
         // RdData holds between reads of the same port.
         if (core_rd) begin
            CoreRdData <= MemRdData;
         end
         if (host_rd) begin
            HostRdData <= MemRdData;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------------
   a_one_grant : assert property (@(posedge Clk) disable iff (!Reset_n)
      !(core_gnt && host_gnt));

   a_one_valid : assert property (@(posedge Clk) disable iff (!Reset_n)
      !(CoreValid && HostValid));

   a_hold_range : assert property (@(posedge Clk) disable iff (!Reset_n)
      hold_cnt <= HOLD_MAX);

endmodule
